// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared constants, field positions and FSM encoding for the
//               direct-mapped instruction cache and its line store.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int WORD_SIZE      = 16;
    localparam int INDEX_BITS     = 2;
    localparam int OFFSET_BITS    = 2;
    localparam int TAG_BITS       = WORD_SIZE - INDEX_BITS - OFFSET_BITS;
    localparam int NUM_LINES      = 1 << INDEX_BITS;
    localparam int WORDS_PER_LINE = 1 << OFFSET_BITS;
    localparam int LINE_BITS      = WORD_SIZE * WORDS_PER_LINE;

    // Field positions within a fetch word address
    localparam int OFFSET_LSB     = 0;
    localparam int INDEX_LSB      = OFFSET_BITS;
    localparam int TAG_LSB        = OFFSET_BITS + INDEX_BITS;

    typedef logic [TAG_BITS-1:0]    tag_t;
    typedef logic [INDEX_BITS-1:0]  index_t;
    typedef logic [OFFSET_BITS-1:0] offset_t;
    typedef logic [LINE_BITS-1:0]   line_t;
    typedef logic [WORD_SIZE-1:0]   word_t;

    typedef enum logic [0:0] {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_e;

    // Word k of a line occupies bits [16k+15:16k]
    function automatic word_t line_word(input line_t line, input offset_t off);
        return line[int'(off) * WORD_SIZE +: WORD_SIZE];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : icache_line_store
// Description : Valid/tag/data arrays of the instruction cache.
//               Combinational read by index, synchronous single-line write,
//               synchronous clear of all valid bits.
// Ports       : Clk, Reset_N      - clock, synchronous active-low reset
//               clr_all           - clear every valid bit (wins over write)
//               rd_index          - lookup index
//               rd_valid/tag/line - state of the indexed line
//               wr_en/index/tag/line - refill write port
// Revision    : 1.0 - initial release
// ============================================================================
module icache_line_store
    import icache_pkg::*;
(
    input  logic   Clk,
    input  logic   Reset_N,
    input  logic   clr_all,
    input  index_t rd_index,
    output logic   rd_valid,
    output tag_t   rd_tag,
    output line_t  rd_line,
    input  logic   wr_en,
    input  index_t wr_index,
    input  tag_t   wr_tag,
    input  line_t  wr_line
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    tag_t                 tag_q  [NUM_LINES];
    tag_t                 tag_d  [NUM_LINES];
    line_t                data_q [NUM_LINES];
    line_t                data_d [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (clr_all) begin
            valid_d = '0;
        end else if (wr_en) begin
            valid_d[wr_index] = 1'b1;
            tag_d[wr_index]   = wr_tag;
            data_d[wr_index]  = wr_line;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data are qualified by the valid bit, so they need no reset
    always_ff @(posedge Clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

endmodule
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped read-only instruction cache. Hits are served
//               combinationally; a miss stalls fetch (i_ready low) while one
//               4-word line is refilled through the m_readM/m_ready handshake.
// Ports       : Clk, Reset_N          - clock, synchronous active-low reset
//               readM1/address1/data1 - datapath fetch port
//               i_ready               - hit this cycle (low = stall)
//               inv                   - invalidate all lines
//               m_readM/m_address     - registered line request to memory
//               m_data/m_ready        - line returned from memory
//               hit_count/miss_count  - only with ICACHE_STATS_EN defined
// Config      : ICACHE_STATS_EN adds the two statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 readM1,
    input  logic [WORD_SIZE-1:0] address1,
    output logic [WORD_SIZE-1:0] data1,
    output logic                 i_ready,
    input  logic                 inv,
    output logic                 m_readM,
    output logic [WORD_SIZE-1:0] m_address,
    input  logic [LINE_BITS-1:0] m_data,
    input  logic                 m_ready
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
`endif
);

    icache_state_e        state_q, state_d;
    logic                 m_readM_q, m_readM_d;
    logic [WORD_SIZE-1:0] m_address_q, m_address_d;
    index_t               fill_index_q, fill_index_d;
    tag_t                 fill_tag_q, fill_tag_d;

    tag_t    req_tag;
    index_t  req_index;
    offset_t req_offset;
    logic    rd_valid;
    tag_t    rd_tag;
    line_t   rd_line;
    logic    lookup;
    logic    hit;
    logic    miss;
    logic    wr_en;
    logic    clr_all;

    assign req_tag    = address1[TAG_LSB    +: TAG_BITS];
    assign req_index  = address1[INDEX_LSB  +: INDEX_BITS];
    assign req_offset = address1[OFFSET_LSB +: OFFSET_BITS];

    icache_line_store u_store (
        .Clk      (Clk),
        .Reset_N  (Reset_N),
        .clr_all  (clr_all),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_index (fill_index_q),
        .wr_tag   (fill_tag_q),
        .wr_line  (m_data)
    );

    // Lookups happen only in IDLE; Reset_N gating keeps the fetch port quiet
    // while reset is held, whatever the arrays contain.
    always_comb begin
        lookup  = Reset_N && readM1 && (state_q == ICACHE_IDLE) && !inv;
        hit     = lookup && rd_valid && (rd_tag == req_tag);
        miss    = lookup && !hit;
        i_ready = hit;
        data1   = hit ? line_word(rd_line, req_offset) : '0;
    end

    always_comb begin
        state_d      = state_q;
        m_readM_d    = m_readM_q;
        m_address_d  = m_address_q;
        fill_index_d = fill_index_q;
        fill_tag_d   = fill_tag_q;
        wr_en        = 1'b0;
        clr_all      = 1'b0;

        if (inv) begin
            // Abandons any fill in flight; a late m_ready then lands in IDLE
            state_d   = ICACHE_IDLE;
            m_readM_d = 1'b0;
            clr_all   = 1'b1;
        end else begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (miss) begin
                        state_d      = ICACHE_FILL;
                        m_readM_d    = 1'b1;
                        m_address_d  = {address1[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                        fill_index_d = req_index;
                        fill_tag_d   = req_tag;
                    end
                end
                ICACHE_FILL: begin
                    // address1 is ignored here: the latched line is filled
                    if (m_ready) begin
                        wr_en     = 1'b1;
                        state_d   = ICACHE_IDLE;
                        m_readM_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ICACHE_IDLE;
                    m_readM_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q      <= ICACHE_IDLE;
            m_readM_q    <= 1'b0;
            m_address_q  <= '0;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            m_readM_q    <= m_readM_d;
            m_address_q  <= m_address_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
        end
    end

    assign m_readM   = m_readM_q;
    assign m_address = m_address_q;

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    // hit/miss are already suppressed while inv is high
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (inv) begin
            hit_count_d  = '0;
            miss_count_d = '0;
        end else begin
            if (hit) begin
                hit_count_d = hit_count_q + 16'd1;
            end
            if (miss) begin
                miss_count_d = miss_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule
`default_nettype wire
